ipml_fifo_mc_v2_sync: RTL
=========================

# ipml_fifo_mc_v2_sync

Multi-channel synchronous FIFO: one inferred simple-dual-port storage array partitioned into `c_CHANNELS` independent FIFOs of 2^`c_DEPTH_WIDTH` words each. It provides one write and one read per cycle, each addressed to any channel. Each channel has its own full, empty, almost and water-level status, plus sticky overflow and underflow flags. It sits in the single-clock DDR read/write datapath, where several video streams share one block of buffer RAM.

## Interface
- `c_CHANNELS`, 4, number of channels, 1..8.
- `c_DEPTH_WIDTH`, 9, per-channel depth width, 4..12; depth D = 2^`c_DEPTH_WIDTH`.
- `c_DATA_WIDTH`, 32, word width, 1..256.
- `c_OUTPUT_REG`, 0, 1 adds an output register stage, giving read latency 2.
- `c_ALMOST_FULL_NUM`, D-4, almost_full threshold, in words.
- `c_ALMOST_EMPTY_NUM`, 4, almost_empty threshold, in words.
- Derived: CW = max(1, clog2(`c_CHANNELS`)); LW = `c_DEPTH_WIDTH`+1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: write request.
- `wr_ch` in CW: write channel.
- `wr_data` in `c_DATA_WIDTH`: write word.
- `rd_en` in 1: read request.
- `rd_ch` in CW: read channel.
- `rd_data` out `c_DATA_WIDTH`: read word.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `rd_data_ch` out CW: channel of the word on `rd_data`.
- `wr_full` out `c_CHANNELS`: per-channel full.
- `rd_empty` out `c_CHANNELS`: per-channel empty.
- `almost_full` out `c_CHANNELS`: per-channel almost full.
- `almost_empty` out `c_CHANNELS`: per-channel almost empty.
- `water_level` out `c_CHANNELS`*LW: per-channel occupancy; channel k is at bits [k*LW +: LW].
- `overflow` out `c_CHANNELS`: sticky; a write was rejected.
- `underflow` out `c_CHANNELS`: sticky; a read was rejected.
- `err_clr` in 1: clears all sticky flags.

## Operation
- Storage address is {channel, ptr[`c_DEPTH_WIDTH`-1:0]}. Total size is `c_CHANNELS`*D words.
- Each channel has an LW-bit write pointer and an LW-bit read pointer. Both wrap modulo 2^LW.
- Each channel has a count, which equals `water_level`.
- A write is accepted iff `wr_en`, `wr_ch` < `c_CHANNELS`, and `wr_full`[`wr_ch`]=0. The full decision uses the registered state only; a same-cycle read does not free space.
- A read is accepted iff `rd_en`, `rd_ch` < `c_CHANNELS`, and `rd_empty`[`rd_ch`]=0. The empty decision uses the registered state only; a same-cycle write does not supply data.
- An accepted write stores the word at the channel's write pointer and increments the write pointer.
- An accepted read fetches the word at the channel's read pointer and increments the read pointer.
- Count update per channel: +1 on write only, -1 on read only, unchanged when both hit the same channel.
- Status flags are registered and reflect the post-update count on the same edge:
  - full = (count == D)
  - empty = (count == 0)
  - almost_full = (count >= `c_ALMOST_FULL_NUM`)
  - almost_empty = (count <= `c_ALMOST_EMPTY_NUM`)
- Read/write address collision cannot occur: reads only target stored words, and a write is rejected when the channel is full.
- Rejected `wr_en` on a valid channel sets `overflow`[ch]. Rejected `rd_en` on a valid channel sets `underflow`[ch].
- Requests to an out-of-range channel are ignored and set no flag.
- `err_clr` clears both sticky vectors. A flag set in the same cycle as `err_clr` wins, so the flag remains 1.
- Per-channel FIFO order is preserved. Channels never affect each other's data or flags.

## Timing
- Reset values:
  - pointers and counts 0
  - `rd_empty` all 1, `wr_full` all 0
  - `almost_empty` all 1 (count 0 <= threshold), `almost_full` all 0
  - `water_level` 0
  - `overflow` and `underflow` 0
  - `rd_valid` 0, `rd_data` 0, `rd_data_ch` 0
- `rst` overrides all other inputs in its cycle. Reads in flight are discarded, and `rd_valid` is 0 in every cycle after `rst` until a new accepted read completes.
- `c_OUTPUT_REG`=0: a read accepted at edge N gives `rd_valid`=1 with data and `rd_data_ch` after edge N+1.
- `c_OUTPUT_REG`=1: the same outputs appear after edge N+2.
- `rd_valid` is a single-cycle pulse per accepted read. Back-to-back reads stream at one word per cycle.
- `rd_data` holds its last value while `rd_valid`=0.
- Flags and `water_level` change at the edge that samples the request, with no lag.
- Write-to-read turnaround: a word written at edge N is readable from cycle N+1, because `rd_empty` has dropped.

## Test plan
- Reset: assert `rst` for 2 cycles mid-traffic, then check every output against its reset value and that `rd_valid` stays 0.
- Fill channel 2 (`c_DEPTH_WIDTH`=4, D=16) with 17 writes of 0..16:
  - `almost_full` at count 12 (`c_ALMOST_FULL_NUM`=12)
  - `wr_full` after 16 writes
  - 17th write rejected and `overflow`[2]=1
  - other channels' flags unchanged
- Interleaved traffic:
  - writes alternate ch0=0xA0+i and ch1=0xB0+i, 8 each
  - reads alternate channels
  - each channel returns its own sequence in order, with `rd_data_ch` correct
- Simultaneous write and read on the same channel:
  - at count 16: the read is accepted, the write is rejected, count becomes 15, and `overflow` is set
  - at count 0: the write is accepted, the read is rejected, count becomes 1, and `underflow` is set
- Wrap-around: stream 100 words through channel 0 with write and read each cycle, keeping the level at 3. Data stays in order and `water_level` stays 3.
- Latency: with `c_OUTPUT_REG`=1, a read accepted at edge N gives `rd_valid` after edge N+2. Assert `rst` at N+1 and check that `rd_valid` never asserts.

Source files
------------

// File: rtl/ipml_fifo_mc_v2_sync_if.sv
// Write/read request bus of the multi-channel FIFO.
// The master side issues writes and reads; the slave side is the FIFO itself.
interface ipml_fifo_mc_v2_sync_if #(
    parameter int c_CHANNELS   = 4,
    parameter int c_DATA_WIDTH = 32
);
    localparam int CW = (c_CHANNELS > 1) ? $clog2(c_CHANNELS) : 1;

    logic                    wr_en;
    logic [CW-1:0]           wr_ch;
    logic [c_DATA_WIDTH-1:0] wr_data;
    logic                    rd_en;
    logic [CW-1:0]           rd_ch;
    logic [c_DATA_WIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic [CW-1:0]           rd_data_ch;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, rd_ch,
        input  rd_data, rd_valid, rd_data_ch
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, rd_ch,
        output rd_data, rd_valid, rd_data_ch
    );
endinterface

// File: rtl/ipml_fifo_mc_v2_sync.sv
// Multi-channel synchronous FIFO: one shared storage array split into c_CHANNELS
// independent FIFOs, one write and one read per cycle, per-channel status.
module ipml_fifo_mc_v2_sync #(
    parameter int c_CHANNELS         = 4,
    parameter int c_DEPTH_WIDTH      = 9,
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_OUTPUT_REG       = 0,
    parameter int c_ALMOST_FULL_NUM  = (1 << c_DEPTH_WIDTH) - 4,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    ipml_fifo_mc_v2_sync_if.slave                     bus,
    input  logic                                      err_clr,
    output logic [c_CHANNELS-1:0]                     wr_full,
    output logic [c_CHANNELS-1:0]                     rd_empty,
    output logic [c_CHANNELS-1:0]                     almost_full,
    output logic [c_CHANNELS-1:0]                     almost_empty,
    output logic [c_CHANNELS*(c_DEPTH_WIDTH+1)-1:0]   water_level,
    output logic [c_CHANNELS-1:0]                     overflow,
    output logic [c_CHANNELS-1:0]                     underflow
);
    localparam int D  = 1 << c_DEPTH_WIDTH;
    localparam int CW = (c_CHANNELS > 1) ? $clog2(c_CHANNELS) : 1;
    localparam int LW = c_DEPTH_WIDTH + 1;
    localparam int AW = CW + c_DEPTH_WIDTH;

    localparam logic [LW-1:0] FULL_LVL = LW'(D);
    localparam logic [LW-1:0] AF_LVL   = LW'(c_ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_LVL   = LW'(c_ALMOST_EMPTY_NUM);

    logic [c_DATA_WIDTH-1:0]  mem [0:c_CHANNELS*D-1];

    logic [LW-1:0]            wr_ptr    [c_CHANNELS];
    logic [LW-1:0]            rd_ptr    [c_CHANNELS];
    logic [LW-1:0]            count     [c_CHANNELS];
    logic [LW-1:0]            count_nxt [c_CHANNELS];

    logic [c_CHANNELS-1:0]    wr_sel, rd_sel, wr_acc, rd_acc;
    logic [c_DEPTH_WIDTH-1:0] wr_idx, rd_idx;
    logic [AW-1:0]            wr_addr, rd_addr;

    logic                     s1_valid;
    logic [c_DATA_WIDTH-1:0]  s1_data;
    logic [CW-1:0]            s1_ch;

    // Out-of-range channel codes match no k, so they are dropped without flags.
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        wr_idx = '0;
        rd_idx = '0;
        for (int k = 0; k < c_CHANNELS; k++) begin
            if (bus.wr_en && (bus.wr_ch == CW'(k))) begin
                wr_sel[k] = 1'b1;
                wr_idx    = wr_ptr[k][c_DEPTH_WIDTH-1:0];
            end
            if (bus.rd_en && (bus.rd_ch == CW'(k))) begin
                rd_sel[k] = 1'b1;
                rd_idx    = rd_ptr[k][c_DEPTH_WIDTH-1:0];
            end
        end
        wr_acc  = wr_sel & ~wr_full;
        rd_acc  = rd_sel & ~rd_empty;
        wr_addr = {bus.wr_ch, wr_idx};
        rd_addr = {bus.rd_ch, rd_idx};
    end

    always_comb begin
        for (int k = 0; k < c_CHANNELS; k++) begin
            count_nxt[k] = count[k];
            case ({wr_acc[k], rd_acc[k]})
                2'b10:   count_nxt[k] = count[k] + LW'(1);
                2'b01:   count_nxt[k] = count[k] - LW'(1);
                default: count_nxt[k] = count[k];
            endcase
        end
    end

    always_comb begin
        water_level = '0;
        for (int k = 0; k < c_CHANNELS; k++) begin
            water_level[k*LW +: LW] = count[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_CHANNELS; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            wr_full      <= '0;
            rd_empty     <= '1;
            almost_full  <= '0;
            almost_empty <= '1;
            overflow     <= '0;
            underflow    <= '0;
        end else begin
            for (int k = 0; k < c_CHANNELS; k++) begin
                if (wr_acc[k]) wr_ptr[k] <= wr_ptr[k] + LW'(1);
                if (rd_acc[k]) rd_ptr[k] <= rd_ptr[k] + LW'(1);
                count[k]        <= count_nxt[k];
                wr_full[k]      <= (count_nxt[k] == FULL_LVL);
                rd_empty[k]     <= (count_nxt[k] == '0);
                almost_full[k]  <= (count_nxt[k] >= AF_LVL);
                almost_empty[k] <= (count_nxt[k] <= AE_LVL);
                // A new rejection in the clear cycle keeps the flag set.
                overflow[k]     <= (wr_sel[k] & wr_full[k])  | (overflow[k]  & ~err_clr);
                underflow[k]    <= (rd_sel[k] & rd_empty[k]) | (underflow[k] & ~err_clr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (|wr_acc)) mem[wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_ch    <= '0;
        end else begin
            s1_valid <= |rd_acc;
            if (|rd_acc) begin
                s1_data <= mem[rd_addr];
                s1_ch   <= bus.rd_ch;
            end
        end
    end

    generate
        if (c_OUTPUT_REG != 0) begin : g_out_reg
            logic                    s2_valid;
            logic [c_DATA_WIDTH-1:0] s2_data;
            logic [CW-1:0]           s2_ch;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_ch    <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                        s2_ch   <= s1_ch;
                    end
                end
            end

            assign bus.rd_valid   = s2_valid;
            assign bus.rd_data    = s2_data;
            assign bus.rd_data_ch = s2_ch;
        end else begin : g_no_out_reg
            assign bus.rd_valid   = s1_valid;
            assign bus.rd_data    = s1_data;
            assign bus.rd_data_ch = s1_ch;
        end
    endgenerate
endmodule
